rvm_ifu: RTL
============

Name: rvm_ifu

Overview:
Instruction fetch unit, directly downstream of the program counter unit. On a fetch request from the control FSM it:
- samples the current PC and checks alignment;
- runs a request/grant/response transaction on the instruction memory port;
- latches the returned word into the instruction register and precomputes PC+4, which feeds the PC write-data path.
It reports completion or error to the control FSM with a single-cycle pulse.

Parameters:
RESET_INSTR, 32'h00000013, instruction register value after reset (ADDI x0,x0,0 NOP).
TIMEOUT_CYCLES, 64, maximum cycles spent in RESP waiting for imem_rvalid before a timeout error; legal range 1..255.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
fetch_req  input  1  start a fetch (level-sampled in IDLE only)
pc  input  32  current program counter from the PCU
busy  output  1  high in any state other than IDLE
fetch_done  output  1  one-cycle pulse: fetch finished (with or without error)
fetch_err  output  1  valid with fetch_done: fetch failed
err_cause  output  2  valid with fetch_done: 0 none, 1 misaligned, 2 bus error, 3 timeout
instr  output  32  instruction register
pc_plus4  output  32  registered (sampled PC + 4), modulo 2^32
imem_req  output  1  memory request valid
imem_addr  output  32  memory request address (sampled PC)
imem_gnt  input  1  memory accepts the request this cycle
imem_rvalid  input  1  response valid
imem_rdata  input  32  response data
imem_err  input  1  response carries a bus error (qualified by imem_rvalid)

Behaviour:
- Clock and reset: all state updates on posedge clk. reset is synchronous and active-high and dominates all other inputs.
- Reset values:
  - state = IDLE, busy = 0, fetch_done = 0, fetch_err = 0, err_cause = 0;
  - instr = RESET_INSTR, pc_plus4 = 0, imem_req = 0, imem_addr = 0;
  - timeout counter = 0.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - On fetch_req: register pc into imem_addr and pc + 4 into pc_plus4.
  - If pc[1:0] != 0: go to DONE with cause 1; no memory request is issued.
  - Otherwise: go to REQ.
- REQ:
  - imem_req = 1; imem_addr is held stable.
  - Stays in REQ until imem_gnt = 1, then goes to RESP. There is no timeout in REQ.
- RESP:
  - imem_req = 0. The counter is cleared on entry and increments every cycle.
  - imem_rvalid is honoured only in RESP (never in the same cycle as the grant).
  - On imem_rvalid && !imem_err: instr <= imem_rdata, cause 0, go to DONE.
  - On imem_rvalid && imem_err: instr is unchanged, cause 2, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES with no rvalid: cause 3, go to DONE. A later stray rvalid is ignored.
- DONE:
  - fetch_done = 1 for exactly one cycle; fetch_err = (cause != 0); err_cause = cause.
  - Then go to IDLE. fetch_done and fetch_err are 0 in all other states.
- Latency:
  - Minimum fetch_req to fetch_done is 3 cycles (IDLE→REQ→RESP→DONE, with gnt and rvalid each at the earliest opportunity).
  - A misaligned fetch gives fetch_done 1 cycle after the fetch_req edge.
- Boundary conditions:
  - fetch_req while busy is ignored.
  - A fetch_req asserted during DONE is not honoured until IDLE.
  - pc changing after sampling has no effect on the fetch in flight.
  - pc = 32'hFFFFFFFC gives pc_plus4 = 0 (wraps silently).
  - instr and pc_plus4 hold their values until the next successful fetch or sampling. pc_plus4 updates on every accepted fetch_req, including misaligned ones.
  - Reset mid-transaction: return to IDLE at the next edge and drop imem_req. A response arriving after reset is ignored.

Decomposition:
- Add to rvm_constants.v:
  - state encodings (RVM_IFU_IDLE/REQ/RESP/DONE);
  - error cause codes (RVM_IFU_ERR_NONE/MISALIGN/BUS/TIMEOUT);
  - RVM_NOP_INSTR for the RESET_INSTR default.
- Single module; no sub-module is warranted. The timeout counter is 8 bits, inline.

Test Plan:
- Reset with all inputs toggling → after release: instr = 32'h00000013, imem_req = 0, busy = 0, pc_plus4 = 0.
- pc = 32'h00000100, fetch_req, gnt immediate, rvalid next cycle with rdata = 32'h00500093 → imem_addr = 0x100, fetch_done on cycle 3 with err = 0, instr = 0x00500093, pc_plus4 = 0x104.
- pc = 32'h00000102, fetch_req → no imem_req ever; fetch_done + fetch_err with err_cause = 1 one cycle later; instr unchanged.
- Grant withheld for 5 cycles, then rvalid with imem_err = 1 → imem_req held 6 cycles with stable addr; err_cause = 2; instr unchanged.
- Granted request, rvalid never asserted, TIMEOUT_CYCLES = 4 → fetch_done with err_cause = 3 after 4 RESP cycles; a stray rvalid afterwards leaves instr unchanged and no extra fetch_done.
- pc = 32'hFFFFFFFC successful fetch → pc_plus4 = 0. Also assert reset while in RESP → IDLE next cycle, busy = 0, and a subsequent rvalid is ignored.

Source files
------------

// File: rtl/rvm_ifu_pkg.sv
// Shared encodings for the rvm instruction fetch unit: FSM states, fetch error
// causes and the reset-time NOP instruction.
package rvm_ifu_pkg;

  typedef enum logic [1:0] {
    RVM_IFU_IDLE = 2'd0,
    RVM_IFU_REQ  = 2'd1,
    RVM_IFU_RESP = 2'd2,
    RVM_IFU_DONE = 2'd3
  } ifu_state_e;

  typedef enum logic [1:0] {
    RVM_IFU_ERR_NONE     = 2'd0,
    RVM_IFU_ERR_MISALIGN = 2'd1,
    RVM_IFU_ERR_BUS      = 2'd2,
    RVM_IFU_ERR_TIMEOUT  = 2'd3
  } ifu_cause_e;

  // ADDI x0,x0,0
  localparam logic [31:0] RVM_NOP_INSTR = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/rvm_ifu.sv
// Instruction fetch unit: samples the PC, runs one req/gnt/rvalid transaction on
// the instruction memory port and reports completion or error with a pulse.
module rvm_ifu
  import rvm_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_INSTR    = RVM_NOP_INSTR,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  output logic        busy,
  output logic        fetch_done,
  output logic        fetch_err,
  output logic [1:0]  err_cause,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err
);

  // Counter value seen in the last RESP cycle before the timeout fires.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  ifu_state_e  state_q;
  ifu_cause_e  err_cause_q;
  ifu_cause_e  resp_cause_d;
  logic        busy_q;
  logic        fetch_done_q;
  logic        fetch_err_q;
  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic [31:0] pc_plus4_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;

  always_comb begin
    pc_plus4_d   = pc + 32'd4;
    cnt_d        = cnt_q + 8'd1;
    resp_cause_d = imem_err ? RVM_IFU_ERR_BUS : RVM_IFU_ERR_NONE;
  end

  // Status outputs are registered on entry to the state they describe, so
  // fetch_done/err_cause are decided on the edge that moves into DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RVM_IFU_IDLE;
      err_cause_q  <= RVM_IFU_ERR_NONE;
      busy_q       <= 1'b0;
      fetch_done_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      instr_q      <= RESET_INSTR;
      pc_plus4_q   <= '0;
      cnt_q        <= '0;
    end else begin
      fetch_done_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      err_cause_q  <= RVM_IFU_ERR_NONE;
      case (state_q)
        RVM_IFU_IDLE: begin
          if (fetch_req) begin
            imem_addr_q <= pc;
            pc_plus4_q  <= pc_plus4_d;
            busy_q      <= 1'b1;
            if (!is_word_aligned(pc)) begin
              state_q      <= RVM_IFU_DONE;
              fetch_done_q <= 1'b1;
              fetch_err_q  <= 1'b1;
              err_cause_q  <= RVM_IFU_ERR_MISALIGN;
            end else begin
              state_q    <= RVM_IFU_REQ;
              imem_req_q <= 1'b1;
            end
          end
        end
        RVM_IFU_REQ: begin
          if (imem_gnt) begin
            state_q    <= RVM_IFU_RESP;
            imem_req_q <= 1'b0;
            cnt_q      <= '0;
          end
        end
        RVM_IFU_RESP: begin
          cnt_q <= cnt_d;
          if (imem_rvalid) begin
            if (!imem_err) begin
              instr_q <= imem_rdata;
            end
            state_q      <= RVM_IFU_DONE;
            fetch_done_q <= 1'b1;
            fetch_err_q  <= imem_err;
            err_cause_q  <= resp_cause_d;
          end else if (cnt_q == TO_LAST) begin
            state_q      <= RVM_IFU_DONE;
            fetch_done_q <= 1'b1;
            fetch_err_q  <= 1'b1;
            err_cause_q  <= RVM_IFU_ERR_TIMEOUT;
          end
        end
        RVM_IFU_DONE: begin
          state_q <= RVM_IFU_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= RVM_IFU_IDLE;
          busy_q     <= 1'b0;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign fetch_done = fetch_done_q;
  assign fetch_err  = fetch_err_q;
  assign err_cause  = err_cause_q;
  assign instr      = instr_q;
  assign pc_plus4   = pc_plus4_q;
  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;

endmodule
